// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the immediate generator: format codes, RV32 opcodes
// and the buffer occupancy encoding.
package imm_gen_pipe_pkg;

  typedef logic [2:0] fmt_t;

  localparam fmt_t FMT_R   = 3'd0;
  localparam fmt_t FMT_I   = 3'd1;
  localparam fmt_t FMT_S   = 3'd2;
  localparam fmt_t FMT_B   = 3'd3;
  localparam fmt_t FMT_U   = 3'd4;
  localparam fmt_t FMT_J   = 3'd5;
  localparam fmt_t FMT_ERR = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32 immediate decode; the 32-bit immediate is built first
// and then sign-extended from bit 31 to XLEN for every format, U included.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            err
);

  logic [31:0] imm32;

  always_comb begin
    fmt   = FMT_ERR;
    err   = 1'b0;
    imm32 = '0;
    case (inst[6:0])
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {inst[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_REG: fmt = FMT_R;
      default: err = 1'b1;
    endcase
    imm = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a valid/ready output buffer: an output register
// plus an optional skid register so in_ready can be driven from a flop.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            imm_err
);

  logic [XLEN-1:0] dec_imm;
  fmt_t            dec_fmt;
  logic            dec_err;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst (inst),
    .imm  (dec_imm),
    .fmt  (dec_fmt),
    .err  (dec_err)
  );

  occ_t            state;
  logic            in_ready_q;
  logic [XLEN-1:0] skid_imm;
  fmt_t            skid_fmt;
  logic            skid_err;
  logic            take_in;
  logic            take_out;

  // Without a skid slot the only way to accept is to free the output register
  // in the same cycle, so readiness has to look at the consumer directly.
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign out_valid = (state != OCC_EMPTY);
  assign take_in   = in_valid && in_ready;
  assign take_out  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OCC_EMPTY;
      in_ready_q <= 1'b1;
      imm        <= '0;
      fmt        <= FMT_R;
      imm_err    <= 1'b0;
      skid_imm   <= '0;
      skid_fmt   <= FMT_R;
      skid_err   <= 1'b0;
    end else if (flush) begin
      state      <= OCC_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (take_in) begin
            imm     <= dec_imm;
            fmt     <= dec_fmt;
            imm_err <= dec_err;
            state   <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (take_in && take_out) begin
            imm     <= dec_imm;
            fmt     <= dec_fmt;
            imm_err <= dec_err;
          end else if (take_in && SKID != 0) begin
            skid_imm   <= dec_imm;
            skid_fmt   <= dec_fmt;
            skid_err   <= dec_err;
            state      <= OCC_FULL;
            in_ready_q <= 1'b0;
          end else if (take_out) begin
            state <= OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (take_out) begin
            imm        <= skid_imm;
            fmt        <= skid_fmt;
            imm_err    <= skid_err;
            state      <= OCC_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= OCC_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, output immediate width; legal values 32 and 64.
REQ-002 Parameter SKID, default 1; 1 gives a 2-entry buffer (output register plus skid register), 0 gives output register only.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  inst is valid this cycle.
REQ-006 in_ready  output  1  block accepts inst this cycle.
REQ-007 inst  input  32  RV32 instruction word.
REQ-008 flush  input  1  discard all buffered entries.
REQ-009 out_valid  output  1  imm/fmt/imm_err are valid.
REQ-010 out_ready  input  1  consumer accepts the output this cycle.
REQ-011 imm  output  XLEN  sign-extended immediate.
REQ-012 fmt  output  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ERR=7.
REQ-013 imm_err  output  1  opcode not recognised.

Function
REQ-014 Opcode inst[6:0] decodes as: 0010011, 0000011, 1100111, 1110011 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J; 0110011 -> R; all others -> ERR.
REQ-015 Immediates: I = sext(inst[31:20]); S = sext(inst[31:25],inst[11:7]); B = sext(inst[31],inst[7],inst[30:25],inst[11:8],0); U = sext(inst[31:12],12'b0); J = sext(inst[31],inst[19:12],inst[20],inst[30:21],0).
REQ-016 sext replicates inst[31] to width XLEN; U-format is also sign-extended from bit 31 when XLEN=64.
REQ-017 R and ERR formats give imm = 0; imm_err = 1 only for ERR.
REQ-018 Transfer-in occurs when in_valid and in_ready are both 1; transfer-out occurs when out_valid and out_ready are both 1.
REQ-019 Latency is 1 cycle: an inst accepted at edge N is presented on imm/fmt at out_valid after edge N, given an empty buffer.
REQ-020 Occupancy states: EMPTY (0 entries), ONE (output register only), FULL (output plus skid; only reachable when SKID=1).
REQ-021 EMPTY + in -> ONE. ONE + in + out -> ONE. ONE + in, no out -> FULL. ONE + out, no in -> EMPTY. FULL + out -> ONE, with the skid entry moving to the output register.
REQ-022 in_ready is a registered signal: 1 in EMPTY and ONE, 0 in FULL. When SKID=0, in_ready = !out_valid | out_ready.
REQ-023 Output order equals acceptance order; no entry is dropped or duplicated.
REQ-024 While out_valid=1 and out_ready=0, imm/fmt/imm_err hold stable.
REQ-025 flush asserted: next state is EMPTY, out_valid=0, in_ready=1; any same-cycle transfer-in is discarded.
REQ-026 flush and a same-cycle transfer-out: the consumer still takes the presented entry.
REQ-027 Decode is combinational on inst; only decoded results are stored, never the raw inst.

Reset
REQ-028 rst=1 at a clock edge forces EMPTY: out_valid=0, in_ready=1, imm=0, fmt=0, imm_err=0.
REQ-029 rst has priority over flush and over any handshake; rst mid-stream discards all entries.

Structure
REQ-030 A shared package holds the fmt codes, opcode constants, and a 3-bit fmt typedef.
REQ-031 One sub-module, imm_decode, holds the combinational decode (inst -> imm, fmt, err, parametrised by XLEN); imm_gen_pipe holds the buffer and handshake logic.

Verification
REQ-032 XLEN=32; inst 0xFFF00093 with out_ready=1 -> one cycle later imm=0xFFFFFFFF, fmt=1, imm_err=0.
REQ-033 XLEN=32; inst 0xFE112E23 -> imm=0xFFFFFFFC, fmt=2.
REQ-034 XLEN=64; inst 0x12345037 -> imm=0x0000000012345000; inst 0x80000037 -> imm=0xFFFFFFFF80000000; fmt=4 for both.
REQ-035 inst 0x0000007F -> fmt=7, imm_err=1, imm=0.
REQ-036 SKID=1 backpressure: out_ready=0, three inst offered back-to-back -> two accepted, in_ready=0 from the cycle after the second; then out_ready=1 -> outputs appear in order, and the third inst is accepted.
REQ-037 flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, no stale output; a later inst flows with 1-cycle latency.
